// File: rtl/parking_pkg.sv
// parking_pkg: shared types for the parking occupancy counter.
//   lot_status_t : encoded lot state driven on the status output.
//   STATUS_W     : width of the status output.
//   lot_status_of: maps an occupancy count onto a lot state.
package parking_pkg;

  localparam int unsigned STATUS_W = 2;

  typedef enum logic [STATUS_W-1:0] {
    ST_EMPTY     = 2'd0,
    ST_FREE      = 2'd1,
    ST_NEAR_FULL = 2'd2,
    ST_FULL      = 2'd3
  } lot_status_t;

  // With margin == 0 the near-full band is empty because count never exceeds cap.
  function automatic lot_status_t lot_status_of(input int unsigned count,
                                                input int unsigned cap,
                                                input int unsigned margin);
    lot_status_t st;
    if (count == 0)                 st = ST_EMPTY;
    else if (count == cap)          st = ST_FULL;
    else if (count >= cap - margin) st = ST_NEAR_FULL;
    else                            st = ST_FREE;
    return st;
  endfunction

endpackage

// File: rtl/sensor_edge_detect.sv
// sensor_edge_detect: rising-edge detector for one gate sensor.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   in    : sensor level
//   pulse : high for the cycle in which a new rising edge is seen
// Macro SENSOR_SYNC_EN: when defined, the sensor passes through a 2-flop
// synchronizer (reset to 0) ahead of the edge detector.
module sensor_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic pulse
);

  logic sampled;
  logic prev_q;

`ifdef SENSOR_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], in};
  end

  assign sampled = sync_q[1];
`else
  assign sampled = in;
`endif

  // History resets to 0, so a sensor already high at reset release
  // registers as one event on the first edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= sampled;
  end

  assign pulse = sampled & ~prev_q;

endmodule

// File: rtl/parking_occupancy_counter.sv
// parking_occupancy_counter: saturating up/down car counter with lot status.
//   clk            : system clock, rising edge
//   rst_n          : asynchronous active-low reset
//   s / r          : entry / exit sensor levels
//   leds           : current occupancy count
//   free_spaces    : CAPACITY - leds
//   full / empty   : leds == CAPACITY / leds == 0 (registered)
//   status         : 0 EMPTY, 1 FREE, 2 NEAR_FULL, 3 FULL (registered)
//   entry_rejected : one-cycle pulse, entry event while full
//   exit_error     : one-cycle pulse, exit event while empty
// Macro SENSOR_SYNC_EN: adds 2-flop sensor synchronizers (3-edge latency).
module parking_occupancy_counter
  import parking_pkg::*;
#(
  parameter int unsigned WIDTH       = 3,
  parameter int unsigned CAPACITY    = 7,
  parameter int unsigned NEAR_MARGIN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s,
  input  logic                r,
  output logic [WIDTH-1:0]    leds,
  output logic [WIDTH-1:0]    free_spaces,
  output logic                full,
  output logic                empty,
  output logic [STATUS_W-1:0] status,
  output logic                entry_rejected,
  output logic                exit_error
);

  if (CAPACITY < 1 || CAPACITY > (2**WIDTH) - 1) begin : g_bad_capacity
    $error("parking_occupancy_counter: CAPACITY out of range for WIDTH");
  end
  if (NEAR_MARGIN >= CAPACITY) begin : g_bad_margin
    $error("parking_occupancy_counter: NEAR_MARGIN must be below CAPACITY");
  end

  localparam logic [WIDTH-1:0] CAP_W = CAPACITY[WIDTH-1:0];

  logic inc, dec;

  sensor_edge_detect u_entry (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (s),
    .pulse (inc)
  );

  sensor_edge_detect u_exit (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (r),
    .pulse (dec)
  );

  logic [WIDTH-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             rej_q, rej_d;
  logic             err_q, err_d;
  lot_status_t      state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      rej_q   <= 1'b0;
      err_q   <= 1'b0;
      state_q <= ST_EMPTY;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      rej_q   <= rej_d;
      err_q   <= err_d;
      state_q <= state_d;
    end
  end

  // Flags and status are derived from the next count so they register on
  // the same edge as the count itself.
  always_comb begin
    count_d = count_q;
    rej_d   = 1'b0;
    err_d   = 1'b0;
    unique case ({inc, dec})
      2'b10: begin
        if (count_q == CAP_W) rej_d   = 1'b1;
        else                  count_d = count_q + 1'b1;
      end
      2'b01: begin
        if (count_q == '0) err_d   = 1'b1;
        else               count_d = count_q - 1'b1;
      end
      default: ;  // no event, or simultaneous entry and exit: hold
    endcase
    full_d  = (count_d == CAP_W);
    empty_d = (count_d == '0);
    state_d = lot_status_of(32'(count_d), CAPACITY, NEAR_MARGIN);
  end

  assign leds           = count_q;
  assign free_spaces    = CAP_W - count_q;
  assign full           = full_q;
  assign empty          = empty_q;
  assign status         = state_q;
  assign entry_rejected = rej_q;
  assign exit_error     = err_q;

endmodule

// File: tb/tb_parking_occupancy_counter.sv
module tb_parking_occupancy_counter;

`ifdef SENSOR_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst_n_a = 1'b1;
  logic rst_n_b = 1'b1;
  logic s = 1'b0;
  logic r = 1'b0;

  logic [2:0] leds_a, free_a;
  logic       full_a, empty_a, rej_a, err_a;
  logic [1:0] status_a;
  logic [4:0] leds_b, free_b;
  logic       full_b, empty_b, rej_b, err_b;
  logic [1:0] status_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  parking_occupancy_counter #(.WIDTH(3), .CAPACITY(7), .NEAR_MARGIN(1)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .s(s), .r(r),
    .leds(leds_a), .free_spaces(free_a), .full(full_a), .empty(empty_a),
    .status(status_a), .entry_rejected(rej_a), .exit_error(err_a)
  );

  parking_occupancy_counter #(.WIDTH(5), .CAPACITY(20), .NEAR_MARGIN(3)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .s(s), .r(r),
    .leds(leds_b), .free_spaces(free_b), .full(full_b), .empty(empty_b),
    .status(status_b), .entry_rejected(rej_b), .exit_error(err_b)
  );

  // Reference model: one entry per DUT instance (0 = defaults, 1 = 5/20/3).
  int m_cnt[2];
  int m_rej[2];
  int m_err[2];
  bit hs[2][3];
  bit hr[2][3];
  bit ps[2];
  bit pr[2];

  function automatic int cap_of(input int d);
    return (d == 0) ? 7 : 20;
  endfunction

  function automatic int margin_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int status_of(input int c, input int cap, input int mg);
    if (c == 0)             return 0;
    else if (c == cap)      return 3;
    else if (c >= cap - mg) return 2;
    else                    return 1;
  endfunction

  task automatic model_reset(input int d);
    m_cnt[d] = 0;
    m_rej[d] = 0;
    m_err[d] = 0;
    for (int i = 0; i < 3; i++) begin
      hs[d][i] = 1'b0;
      hr[d][i] = 1'b0;
    end
    ps[d] = 1'b0;
    pr[d] = 1'b0;
  endtask

  task automatic model_edge(input int d, input logic rst_ok);
    bit es, er, ent, ext;
    if (rst_ok !== 1'b1) begin
      model_reset(d);
    end else begin
      hs[d][2] = hs[d][1]; hs[d][1] = hs[d][0]; hs[d][0] = s;
      hr[d][2] = hr[d][1]; hr[d][1] = hr[d][0]; hr[d][0] = r;
      es = hs[d][LAT];
      er = hr[d][LAT];
      ent = es && !ps[d];
      ext = er && !pr[d];
      ps[d] = es;
      pr[d] = er;
      m_rej[d] = 0;
      m_err[d] = 0;
      if (ent && !ext) begin
        if (m_cnt[d] < cap_of(d)) m_cnt[d] = m_cnt[d] + 1;
        else                      m_rej[d] = 1;
      end else if (ext && !ent) begin
        if (m_cnt[d] > 0) m_cnt[d] = m_cnt[d] - 1;
        else              m_err[d] = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("a_leds",   {29'd0, leds_a},   m_cnt[0]);
    chk("a_free",   {29'd0, free_a},   7 - m_cnt[0]);
    chk("a_full",   {31'd0, full_a},   (m_cnt[0] == 7) ? 1 : 0);
    chk("a_empty",  {31'd0, empty_a},  (m_cnt[0] == 0) ? 1 : 0);
    chk("a_status", {30'd0, status_a}, status_of(m_cnt[0], 7, 1));
    chk("a_rej",    {31'd0, rej_a},    m_rej[0]);
    chk("a_err",    {31'd0, err_a},    m_err[0]);
    chk("b_leds",   {27'd0, leds_b},   m_cnt[1]);
    chk("b_free",   {27'd0, free_b},   20 - m_cnt[1]);
    chk("b_full",   {31'd0, full_b},   (m_cnt[1] == 20) ? 1 : 0);
    chk("b_empty",  {31'd0, empty_b},  (m_cnt[1] == 0) ? 1 : 0);
    chk("b_status", {30'd0, status_b}, status_of(m_cnt[1], 20, 3));
    chk("b_rej",    {31'd0, rej_b},    m_rej[1]);
    chk("b_err",    {31'd0, err_b},    m_err[1]);
  endtask

  task automatic step(input logic si, input logic ri);
    s = si;
    r = ri;
    @(posedge clk);
    model_edge(0, rst_n_a);
    model_edge(1, rst_n_b);
    #1;
    check_all();
  endtask

  // One-cycle sensor pulse followed by enough idle edges for either build.
  task automatic pulse(input logic si, input logic ri);
    step(si, ri);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    #1;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    #2;
    check_all();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;

    // Three separate entries.
    repeat (3) pulse(1'b1, 1'b0);
    chk("three_entries_leds", {29'd0, leds_a}, 3);
    chk("three_entries_free", {29'd0, free_a}, 4);
    chk("three_entries_status", {30'd0, status_a}, 1);

    // Sensor held high counts once.
    repeat (10) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    chk("held_s_leds", {29'd0, leds_a}, 4);

    // Fill to capacity, then one rejected entry.
    repeat (2) pulse(1'b1, 1'b0);
    chk("near_full_status", {30'd0, status_a}, 2);
    pulse(1'b1, 1'b0);
    chk("full_status", {30'd0, status_a}, 3);
    pulse(1'b1, 1'b0);
    chk("reject_hold_leds", {29'd0, leds_a}, 7);

    // Simultaneous entry and exit at capacity.
    pulse(1'b1, 1'b1);
    chk("both_at_full", {29'd0, leds_a}, 7);

    // Down to 4, simultaneous events there.
    repeat (3) pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    chk("both_at_4", {29'd0, leds_a}, 4);

    // Down to 0, exit error, simultaneous at 0.
    repeat (4) pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    chk("exit_error_hold", {29'd0, leds_a}, 0);
    pulse(1'b1, 1'b1);
    chk("both_at_0", {29'd0, leds_a}, 0);

    // Wide instance: empty it, fill past capacity, drain fully.
    repeat (3) pulse(1'b0, 1'b1);
    repeat (21) pulse(1'b1, 1'b0);
    chk("b_full_20", {27'd0, leds_b}, 20);
    repeat (21) pulse(1'b0, 1'b1);
    chk("b_empty_again", {30'd0, status_b}, 0);

    // Asynchronous reset of the wide instance at 12.
    repeat (12) pulse(1'b1, 1'b0);
    chk("b_at_12", {27'd0, leds_b}, 12);
    #2;
    rst_n_b = 1'b0;
    model_reset(1);
    #1;
    chk("b_async_reset_leds", {27'd0, leds_b}, 0);
    check_all();
    step(1'b0, 1'b0);
    rst_n_b = 1'b1;

    // Sensor already high when reset releases.
    rst_n_a = 1'b0;
    model_reset(0);
    step(1'b1, 1'b0);
    rst_n_a = 1'b1;
    repeat (4) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("high_at_release", {29'd0, leds_a}, 1);

    // Random traffic.
    repeat (600) begin
      step(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
